mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: one outstanding data-memory request, IDLE/REQ/WAIT/DONE.
// Optional feature macro MEM_MISALIGN_TRAP_EN adds misalign_o and traps width-misaligned accesses.
module mem_access_unit #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_is_store_i,
    input  logic [DATA_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic [1:0]            ex_wid_i,
    input  logic                  ex_unsigned_i,
    input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]            dmem_wstrb_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic [DATA_WIDTH-1:0] WB_Data,
    output logic                  Mem_REn
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [7:0]            wstrb_reg;
    logic                  req_reg;
    logic                  we_reg;
    logic                  store_reg;

    logic                  mem_op;
    logic                  misaligned;
    logic [2:0]            lane;
    logic [5:0]            bit_shift;
    logic [3:0]            nbytes;
    logic [3:0]            lane_end;
    logic [7:0]            wstrb_next;
    logic [DATA_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] load_data;

    assign mem_op     = ex_valid_i & (ex_is_load_i | ex_is_store_i);
    assign lane       = ex_addr_i[2:0];
    assign bit_shift  = {lane, 3'b000};
    assign nbytes     = 4'd1 << ex_wid_i;
    assign lane_end   = {1'b0, lane} + nbytes;
    assign addr_next  = {ex_addr_i[DATA_WIDTH-1:3], 3'b000};
    assign wdata_next = ex_wdata_i << bit_shift;

    // Strobes run from the start lane for the access width; lanes past 7 simply fall off.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign wstrb_next[gi] = (4'(gi) >= {1'b0, lane}) && (4'(gi) < lane_end);
        end
    endgenerate

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        case (ex_wid_i)
            2'd1:    misaligned = mem_op & ex_addr_i[0];
            2'd2:    misaligned = mem_op & (|ex_addr_i[1:0]);
            2'd3:    misaligned = mem_op & (|ex_addr_i[2:0]);
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Upstream is frozen while stalled, so ex_* still describe the access in DONE.
    assign rdata_shifted = rdata_reg >> bit_shift;

    always_comb begin
        case (ex_wid_i)
            2'd0: load_data = ex_unsigned_i ?
                  {{(DATA_WIDTH-8){1'b0}}, rdata_shifted[7:0]} :
                  {{(DATA_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'd1: load_data = ex_unsigned_i ?
                  {{(DATA_WIDTH-16){1'b0}}, rdata_shifted[15:0]} :
                  {{(DATA_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            2'd2: load_data = ex_unsigned_i ?
                  {{(DATA_WIDTH-32){1'b0}}, rdata_shifted[31:0]} :
                  {{(DATA_WIDTH-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            wstrb_reg <= '0;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            store_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        state_reg <= REQ;
                        req_reg   <= 1'b1;
                        we_reg    <= ex_is_store_i;
                        store_reg <= ex_is_store_i;
                        addr_reg  <= addr_next;
                        wdata_reg <= wdata_next;
                        wstrb_reg <= wstrb_next;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        wstrb_reg <= '0;
                        state_reg <= store_reg ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        rdata_reg <= dmem_rdata_i;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign dmem_req_o   = req_reg;
    assign dmem_we_o    = we_reg;
    assign dmem_addr_o  = addr_reg;
    assign dmem_wdata_o = wdata_reg;
    assign dmem_wstrb_o = wstrb_reg;

    // Reset gates the combinational write-back path so nothing leaks while rst_i is high.
    always_comb begin
        stall_o = 1'b0;
        Mem_REn = 1'b0;
        WB_Data = '0;
        if (!rst_i) begin
            case (state_reg)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        stall_o = 1'b1;
                    end else if (!mem_op) begin
                        WB_Data = ex_alu_result_i;
                    end
                end
                REQ, WAIT: stall_o = 1'b1;
                default: begin
                    if (!store_reg) begin
                        Mem_REn = 1'b1;
                        WB_Data = load_data;
                    end
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o = !rst_i && (state_reg == IDLE) && misaligned;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard, with reset and trap sequences.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_is_load_i, ex_is_store_i, ex_unsigned_i;
    logic [63:0] ex_addr_i, ex_wdata_i, ex_alu_result_i;
    logic [1:0]  ex_wid_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic [63:0] WB_Data;
    logic        Mem_REn;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_access_unit #(.DATA_WIDTH(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i), .ex_is_store_i(ex_is_store_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_wid_i(ex_wid_i),
        .ex_unsigned_i(ex_unsigned_i), .ex_alu_result_i(ex_alu_result_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .WB_Data(WB_Data), .Mem_REn(Mem_REn)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        valid, ld, st, uns;
        logic [1:0]  wid;
        logic [63:0] addr, wdata, alu, rdata;
        int          gnt_dly, rv_dly;
        logic [63:0] exp_wb;
        logic        exp_ren;
        logic [7:0]  exp_strb;
    } vec_t;

    typedef struct {
        logic [63:0] wb;
        logic        ren;
    } exp_t;

    exp_t sb_q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic v, input logic ld, input logic st,
                                input logic [1:0] w, input logic u, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] alu, input logic [63:0] rd,
                                input int g, input int r, input logic [63:0] ewb, input logic eren,
                                input logic [7:0] strb);
        vec_t x;
        x.name = n; x.valid = v; x.ld = ld; x.st = st; x.wid = w; x.uns = u;
        x.addr = a; x.wdata = wd; x.alu = alu; x.rdata = rd; x.gnt_dly = g; x.rv_dly = r;
        x.exp_wb = ewb; x.exp_ren = eren; x.exp_strb = strb;
        return x;
    endfunction

    function automatic logic [63:0] strb_mask(input logic [7:0] s);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic drive(input vec_t v);
        ex_valid_i = v.valid; ex_is_load_i = v.ld; ex_is_store_i = v.st;
        ex_wid_i = v.wid; ex_unsigned_i = v.uns; ex_addr_i = v.addr;
        ex_wdata_i = v.wdata; ex_alu_result_i = v.alu;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t        e;
        int          stalls, reqs, wcnt;
        bit          granted, done, mem;
        logic [63:0] mask, exp_wdata;
        mem       = v.valid && (v.ld || v.st);
        mask      = strb_mask(v.exp_strb);
        exp_wdata = (v.wdata << {v.addr[2:0], 3'b000}) & mask;
        @(posedge clk_i); #1;
        drive(v);
        sb_q.push_back('{wb: v.exp_wb, ren: v.exp_ren});
        stalls = 0; reqs = 0; wcnt = 0; granted = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk_i);
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            if (!stall_o) begin
                e = sb_q.pop_front();
                chk({v.name, ".wb"}, WB_Data, e.wb);
                chk({v.name, ".ren"}, 64'(Mem_REn), 64'(e.ren));
                chk({v.name, ".req_off"}, 64'(dmem_req_o), 64'd0);
                done = 1;
            end else begin
                stalls++;
                if (dmem_req_o) begin
                    reqs++;
                    chk({v.name, ".addr"}, dmem_addr_o, {v.addr[63:3], 3'b000});
                    chk({v.name, ".strb"}, 64'(dmem_wstrb_o), 64'(v.exp_strb));
                    chk({v.name, ".we"}, 64'(dmem_we_o), 64'(v.st));
                    if (v.st) chk({v.name, ".wdata"}, dmem_wdata_o & mask, exp_wdata);
                    if (reqs > v.gnt_dly) begin
                        dmem_gnt_i = 1'b1;
                        granted = 1;
                        // a response in the grant cycle must be ignored
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i = ~v.rdata;
                    end
                end else if (granted) begin
                    if (wcnt == v.rv_dly) begin
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i = v.rdata;
                    end
                    wcnt++;
                end
            end
        end
        if (!done) begin
            tests++; failed++;
            $display("[TB] FAIL %s.timeout: got no completion expected DONE within 60 cycles", v.name);
            void'(sb_q.pop_front());
        end else begin
            chk({v.name, ".stalls"}, 64'(stalls),
                64'(!mem ? 0 : (v.st ? 2 + v.gnt_dly : 3 + v.gnt_dly + v.rv_dly)));
            chk({v.name, ".reqs"}, 64'(reqs), 64'(mem ? v.gnt_dly + 1 : 0));
        end
        $display("[TB] %s: wb=%h ren=%b stalls=%0d reqs=%0d", v.name, WB_Data, Mem_REn, stalls, reqs);
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        // name valid ld st wid uns addr wdata alu rdata gnt rv exp_wb exp_ren strb
        vecs.push_back(mk("alu", 1, 0, 0, 2'd0, 0, 64'h0, 64'h0, 64'h1234, 64'h0, 0, 0, 64'h1234, 0, 8'h00));
        vecs.push_back(mk("invalid", 0, 1, 0, 2'd0, 0, 64'h8, 64'h0, 64'hDEAD, 64'h0, 0, 0, 64'hDEAD, 0, 8'h00));
        vecs.push_back(mk("lb", 1, 1, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 0, 0,
                          64'hFFFF_FFFF_FFFF_FF80, 1, 8'h08));
        vecs.push_back(mk("sh", 1, 0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 64'h0, 64'h0, 2, 0, 64'h0, 0, 8'hC0));
        vecs.push_back(mk("lwu", 1, 1, 0, 2'd2, 1, 64'h10, 64'h0, 64'h0, 64'hFFFF_FFFF_F000_0001, 0, 0,
                          64'h0000_0000_F000_0001, 1, 8'h0F));
        vecs.push_back(mk("lw", 1, 1, 0, 2'd2, 0, 64'h10, 64'h0, 64'h0, 64'hFFFF_FFFF_F000_0001, 0, 0,
                          64'hFFFF_FFFF_F000_0001, 1, 8'h0F));
        vecs.push_back(mk("ld", 1, 1, 0, 2'd3, 0, 64'h18, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 2,
                          64'h0123_4567_89AB_CDEF, 1, 8'hFF));
        vecs.push_back(mk("lhu", 1, 1, 0, 2'd1, 1, 64'h22, 64'h0, 64'h0, 64'h1122_3344_5566_8899, 0, 1,
                          64'h5566, 1, 8'h0C));
        vecs.push_back(mk("lh", 1, 1, 0, 2'd1, 0, 64'h26, 64'h0, 64'h0, 64'h8001_0000_0000_0000, 1, 0,
                          64'hFFFF_FFFF_FFFF_8001, 1, 8'hC0));
        vecs.push_back(mk("sb", 1, 0, 1, 2'd0, 0, 64'h3005, 64'hA5, 64'h0, 64'h0, 0, 0, 64'h0, 0, 8'h20));
        vecs.push_back(mk("sd", 1, 0, 1, 2'd3, 0, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 0, 0,
                          64'h0, 0, 8'hFF));
        vecs.push_back(mk("sw", 1, 0, 1, 2'd2, 0, 64'h4004, 64'hCAFE_BABE, 64'h0, 64'h0, 1, 0, 64'h0, 0, 8'hF0));
        vecs.push_back(mk("lbu7", 1, 1, 0, 2'd0, 1, 64'h7, 64'h0, 64'h0, 64'hF000_0000_0000_0000, 0, 0,
                          64'hF0, 1, 8'h80));
        vecs.push_back(mk("lb7", 1, 1, 0, 2'd0, 0, 64'h7, 64'h0, 64'h0, 64'hF000_0000_0000_0000, 0, 0,
                          64'hFFFF_FFFF_FFFF_FFF0, 1, 8'h80));
`ifndef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_cross", 1, 1, 0, 2'd2, 0, 64'h6, 64'h0, 64'h0, 64'hAABB_CCDD_1122_3344, 0, 0,
                          64'hAABB, 1, 8'hC0));
        vecs.push_back(mk("sw_cross", 1, 0, 1, 2'd2, 0, 64'h6, 64'h1122_3344, 64'h0, 64'h0, 0, 0,
                          64'h0, 0, 8'hC0));
`endif

        // reset state, with an ALU op presented so a leaking write-back would show
        rst_i = 1'b1;
        drive(mk("rst", 1, 0, 0, 2'd0, 0, 64'h0, 64'h0, 64'h55, 64'h0, 0, 0, 64'h0, 0, 8'h0));
        dmem_rdata_i = 64'h0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst.stall", 64'(stall_o), 64'd0);
        chk("rst.req", 64'(dmem_req_o), 64'd0);
        chk("rst.we", 64'(dmem_we_o), 64'd0);
        chk("rst.strb", 64'(dmem_wstrb_o), 64'd0);
        chk("rst.ren", 64'(Mem_REn), 64'd0);
        chk("rst.wb", WB_Data, 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // reset asserted while waiting for read data, then a stray grant/response
        @(posedge clk_i); #1;
        drive(mk("rst_wait", 1, 1, 0, 2'd2, 0, 64'h40, 64'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 8'h0));
        @(negedge clk_i);
        chk("rst_wait.idle_stall", 64'(stall_o), 64'd1);
        @(negedge clk_i);
        chk("rst_wait.req", 64'(dmem_req_o), 64'd1);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        chk("rst_wait.wait_stall", 64'(stall_o), 64'd1);
        #1;
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_alu_result_i = 64'h0;
        #1;
        chk("rst_wait.in_rst_stall", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_gnt_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("rst_wait.stall", 64'(stall_o), 64'd0);
            chk("rst_wait.ren", 64'(Mem_REn), 64'd0);
            chk("rst_wait.wb", WB_Data, 64'd0);
            chk("rst_wait.req", 64'(dmem_req_o), 64'd0);
        end
        $display("[TB] rst_wait: wb=%h ren=%b stall=%b", WB_Data, Mem_REn, stall_o);
        dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0;
        run_vec(vecs[2]);

`ifdef MEM_MISALIGN_TRAP_EN
        @(posedge clk_i); #1;
        drive(mk("mis", 1, 1, 0, 2'd2, 0, 64'h2, 64'h0, 64'h77, 64'h0, 0, 0, 64'h0, 0, 8'h0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("mis.flag", 64'(misalign_o), 64'd1);
            chk("mis.stall", 64'(stall_o), 64'd0);
            chk("mis.req", 64'(dmem_req_o), 64'd0);
            chk("mis.wb", WB_Data, 64'd0);
            chk("mis.ren", 64'(Mem_REn), 64'd0);
        end
        ex_valid_i = 1'b0;
        #1;
        chk("mis.clear", 64'(misalign_o), 64'd0);
        $display("[TB] mis: misalign=%b stall=%b", misalign_o, stall_o);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
